// File: rtl/mii_tx_pkg.sv
// rtl/mii_tx_pkg.sv - shared types and constants for the MII transmitter
package mii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_IFG  = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // 96 bit times at four bits per nibble clock
    localparam int IFG_NIBBLES_DEFAULT = 24;

    // FIFO entry is {last, byte}
    localparam int FIFO_ENTRY_W = 9;

endpackage

// File: rtl/mii_tx_fifo.sv
// rtl/mii_tx_fifo.sv - synchronous FIFO with full/empty flags and registered ready
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write request and data
//   rd_en, rd_data    pop request; rd_data always shows the head entry
//   full, empty       occupancy flags
//   ready             registered !full, held low while in reset
module mii_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_n;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // A simultaneous read lets a write through when full, and a simultaneous
    // write lets a read through when empty; the count is unchanged either way.
    assign do_wr   = wr_en && (!full || rd_en);
    assign do_rd   = rd_en && (!empty || wr_en);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (do_wr && !do_rd) begin
            count_n = count + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_n = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
            ready <= (count_n != FULL_COUNT);
        end
    end

endmodule

// File: rtl/mii_tx.sv
// rtl/mii_tx.sv - MII nibble transmitter: byte FIFO, nibble serialiser, inter-frame gap, underrun handling
// Optional feature macro: MII_TX_UNDERRUN_EN (underrun flagged on TX_ER with TX_EN held, instead of TX_EN dropping)
// Ports:
//   in_txc, in_rst_n              nibble clock, asynchronous active-low reset
//   in_txen, in_txd, in_txlast    upstream byte stream (transfer when in_txen && out_ready)
//   out_ready                     FIFO can accept a byte
//   out_txen, out_txd, out_txer   MII TX_EN / TXD / TX_ER
//   out_busy                      transmitter not idle
module mii_tx
    import mii_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int IFG_NIBBLES = IFG_NIBBLES_DEFAULT
) (
    input  logic       in_txc,
    input  logic       in_rst_n,
    input  logic       in_txen,
    input  logic [7:0] in_txd,
    input  logic       in_txlast,
    output logic       out_ready,
    output logic       out_txen,
    output logic [3:0] out_txd,
    output logic       out_txer,
    output logic       out_busy
);
    localparam int GAP_W = $clog2(IFG_NIBBLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_NIBBLES - 1);

    state_t                  state, state_n;
    logic [GAP_W-1:0]        gap, gap_n;
    logic [3:0]              held_hi, held_hi_n;
    logic                    held_last, held_last_n;
    logic                    txen_q, txen_n;
    logic [3:0]              txd_q, txd_n;
    logic                    load;
    logic                    pop;
    logic                    fifo_wr;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FIFO_ENTRY_W-1:0] fifo_head;
`ifdef MII_TX_UNDERRUN_EN
    logic                    urun, urun_n;
    logic                    txer_q, txer_n;
`endif

    assign fifo_wr = in_txen && out_ready && !fifo_full;

    mii_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_ENTRY_W)
    ) u_fifo (
        .clk     (in_txc),
        .rst_n   (in_rst_n),
        .wr_en   (fifo_wr),
        .wr_data ({in_txlast, in_txd}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ready   (out_ready)
    );

    always_comb begin
        state_n     = state;
        gap_n       = gap;
        held_hi_n   = held_hi;
        held_last_n = held_last;
        txen_n      = 1'b0;
        txd_n       = 4'h0;
        load        = 1'b0;
        pop         = 1'b0;
`ifdef MII_TX_UNDERRUN_EN
        urun_n      = urun;
        txer_n      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_LO: begin
                txen_n  = 1'b1;
                txd_n   = held_hi;
                state_n = ST_HI;
            end
            ST_HI: begin
                if (held_last) begin
                    gap_n   = GAP_LOAD;
                    state_n = ST_IFG;
`ifdef MII_TX_UNDERRUN_EN
                end else if (urun) begin
                    // Keep signalling the error until a byte shows up, then
                    // throw away the rest of the frame.
                    if (fifo_empty) begin
                        txen_n = 1'b1;
                        txer_n = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        urun_n = 1'b0;
                        if (fifo_head[FIFO_ENTRY_W-1]) begin
                            gap_n   = GAP_LOAD;
                            state_n = ST_IFG;
                        end else begin
                            state_n = ST_DROP;
                        end
                    end
`endif
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
`ifdef MII_TX_UNDERRUN_EN
                    txen_n = 1'b1;
                    txer_n = 1'b1;
                    urun_n = 1'b1;
`else
                    state_n = ST_DROP;
`endif
                end
            end
            ST_IFG: begin
                // The last gap clock starts a waiting frame directly, so the
                // gap is exactly IFG_NIBBLES clocks rather than one more.
                if (gap == '0) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_n = gap - GAP_W'(1);
                end
            end
            ST_DROP: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (fifo_head[FIFO_ENTRY_W-1]) begin
                        gap_n   = GAP_LOAD;
                        state_n = ST_IFG;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (load) begin
            pop         = 1'b1;
            txen_n      = 1'b1;
            txd_n       = fifo_head[3:0];
            held_hi_n   = fifo_head[7:4];
            held_last_n = fifo_head[FIFO_ENTRY_W-1];
            state_n     = ST_LO;
        end
    end

    always_ff @(posedge in_txc or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= ST_IDLE;
            gap       <= '0;
            held_hi   <= 4'h0;
            held_last <= 1'b0;
            txen_q    <= 1'b0;
            txd_q     <= 4'h0;
`ifdef MII_TX_UNDERRUN_EN
            urun      <= 1'b0;
            txer_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            gap       <= gap_n;
            held_hi   <= held_hi_n;
            held_last <= held_last_n;
            txen_q    <= txen_n;
            txd_q     <= txd_n;
`ifdef MII_TX_UNDERRUN_EN
            urun      <= urun_n;
            txer_q    <= txer_n;
`endif
        end
    end

    assign out_txen = txen_q;
    assign out_txd  = txd_q;
    assign out_busy = (state != ST_IDLE);
`ifdef MII_TX_UNDERRUN_EN
    assign out_txer = txer_q;
`else
    assign out_txer = 1'b0;
`endif

endmodule

// File: tb/tb_mii_tx.sv
// tb/tb_mii_tx.sv - table-driven bench for mii_tx (default gap instance and IFG_NIBBLES=1 instance)
module tb_mii_tx;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       txen_i = 1'b0;
    logic [7:0] txd_i  = 8'h00;
    logic       last_i = 1'b0;

    logic       ready0, txen0, txer0, busy0;
    logic [3:0] txd0;
    logic       ready1, txen1, txer1, busy1;
    logic [3:0] txd1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mii_tx dut0 (
        .in_txc    (clk),
        .in_rst_n  (rst_n),
        .in_txen   (txen_i),
        .in_txd    (txd_i),
        .in_txlast (last_i),
        .out_ready (ready0),
        .out_txen  (txen0),
        .out_txd   (txd0),
        .out_txer  (txer0),
        .out_busy  (busy0)
    );

    mii_tx #(.IFG_NIBBLES(1)) dut1 (
        .in_txc    (clk),
        .in_rst_n  (rst_n),
        .in_txen   (txen_i),
        .in_txd    (txd_i),
        .in_txlast (last_i),
        .out_ready (ready1),
        .out_txen  (txen1),
        .out_txd   (txd1),
        .out_txer  (txer1),
        .out_busy  (busy1)
    );

    // exp packs {ready, busy, txer, txen, txd[3:0]} of dut0 after the edge
    typedef struct packed {
        logic       en;
        logic [7:0] d;
        logic       last;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [7:0] out0();
        return {ready0, busy0, txer0, txen0, txd0};
    endfunction

    function automatic logic [7:0] out1();
        return {ready1, busy1, txer1, txen1, txd1};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic en, input logic [7:0] d, input logic last, input logic [7:0] exp);
        tbl.push_back('{en: en, d: d, last: last, exp: exp});
    endtask

    task automatic add_nop(input logic [7:0] exp);
        add(1'b0, 8'h00, 1'b0, exp);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            txen_i = tbl[i].en;
            txd_i  = tbl[i].d;
            last_i = tbl[i].last;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s[%0d]", name, i), int'(out0()), int'(tbl[i].exp));
        end
        txen_i = 1'b0;
        txd_i  = 8'h00;
        last_i = 1'b0;
        tbl.delete();
    endtask

    task automatic trace(input logic en, input logic [3:0] d, inout int phase, inout int gap,
                         inout int n, inout logic [63:0] nibs);
        if (en) begin
            nibs = {nibs[59:0], d};
            n++;
        end
        case (phase)
            0: if (en) phase = 1;
            1: if (!en) begin phase = 2; gap = 1; end
            2: if (en) phase = 3; else gap++;
            default: ;
        endcase
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((busy0 || busy1) && c < 200) begin
            @(posedge clk);
            @(negedge clk);
            c++;
        end
        check(name, int'(busy0 || busy1), 0);
    endtask

    initial begin
        logic [7:0]  burst [8];
        logic [63:0] nibs0, nibs1, exp_nibs;
        int          ph0, ph1, gp0, gp1, n0, n1, k, drop_at;
        logic        acc;

        burst = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

        // reset values and ready release
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_out0", int'(out0()), 0);
        check("reset_out1", int'(out1()), 0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", int'(ready0), 0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_edge", int'(ready0), 1);

        // 0xA5, 0x3C(last): nibbles 5,A,C,3 then 24 clocks of gap
        add(1'b1, 8'hA5, 1'b0, 8'h80);
        add(1'b1, 8'h3C, 1'b1, 8'hD5);
        add_nop(8'hDA);
        add_nop(8'hDC);
        add_nop(8'hD3);
        for (int i = 0; i < 24; i++) add_nop(8'hC0);
        add_nop(8'h80);
        run_table("frame");

        // underrun: 0x11, pause, 0x22(last) is discarded
        add(1'b1, 8'h11, 1'b0, 8'h80);
        add_nop(8'hD1);
        add_nop(8'hD1);
`ifdef MII_TX_UNDERRUN_EN
        add_nop(8'hF0);
        add(1'b1, 8'h22, 1'b1, 8'hF0);
`else
        add_nop(8'hC0);
        add(1'b1, 8'h22, 1'b1, 8'hC0);
`endif
        for (int i = 0; i < 24; i++) add_nop(8'hC0);
        add_nop(8'h80);
        run_table("underrun");

        // two queued 1-byte frames: gap 24 on dut0, 1 on dut1
        ph0 = 0; ph1 = 0; gp0 = 0; gp1 = 0; n0 = 0; n1 = 0; nibs0 = '0; nibs1 = '0;
        for (int c = 0; c < 60; c++) begin
            txen_i = (c < 2);
            txd_i  = (c == 0) ? 8'h5A : 8'h96;
            last_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            trace(txen0, txd0, ph0, gp0, n0, nibs0);
            trace(txen1, txd1, ph1, gp1, n1, nibs1);
        end
        txen_i = 1'b0;
        last_i = 1'b0;
        check("gap24_clocks", gp0, 24);
        check("gap24_nibs", int'(nibs0[31:0]), 32'h0000A569);
        check("gap24_count", n0, 4);
        check("gap1_clocks", gp1, 1);
        check("gap1_nibs", int'(nibs1[31:0]), 32'h0000A569);
        check("gap1_count", n1, 4);
        wait_idle("idle_after_gap");

        // 8-byte burst with in_txen held: ready drops at 4 buffered
        k = 0; drop_at = -1; ph0 = 0; gp0 = 0; n0 = 0; nibs0 = '0;
        for (int c = 0; c < 40; c++) begin
            txen_i = (k < 8);
            txd_i  = burst[k[2:0]];
            last_i = (k == 7);
            acc    = txen_i && ready0;
            @(posedge clk);
            @(negedge clk);
            if (acc) k++;
            if (!ready0 && drop_at < 0) drop_at = c;
            trace(txen0, txd0, ph0, gp0, n0, nibs0);
        end
        txen_i = 1'b0;
        last_i = 1'b0;
        exp_nibs = '0;
        for (int i = 0; i < 8; i++) exp_nibs = {exp_nibs[55:0], burst[i][3:0], burst[i][7:4]};
        check("burst_accepted", k, 8);
        check("burst_ready_drop", drop_at, 6);
        check("burst_nibble_count", n0, 16);
        check("burst_nibs_hi", int'(nibs0[63:32]), int'(exp_nibs[63:32]));
        check("burst_nibs_lo", int'(nibs0[31:0]), int'(exp_nibs[31:0]));
        check("burst_contiguous", ph0, 2);
        wait_idle("idle_after_burst");

        // reset pulled during the second byte
        add(1'b1, 8'hA5, 1'b0, 8'h80);
        add(1'b1, 8'h3C, 1'b1, 8'hD5);
        add_nop(8'hDA);
        add_nop(8'hDC);
        run_table("pre_reset");
        #2 rst_n = 1'b0;
        #1 check("async_reset_out0", int'(out0()), 0);
        check("async_reset_out1", int'(out1()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_state", int'(out0()), 8'h80);
        add(1'b1, 8'h7E, 1'b1, 8'h80);
        add_nop(8'hDE);
        add_nop(8'hD7);
        add_nop(8'hC0);
        run_table("post_reset");
        wait_idle("idle_at_end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
